// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state
// encoding, opcode values and the datapath select codes driven by the FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_LUI_WB    = 4'd10,
    S_JR        = 4'd11,
    S_JAL       = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JR    = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier.
// Ports:
//   op          in  6  opcode to classify
//   is_*        out 1  one-hot instruction class flags
//   load_ctl    out 2  load width select
//   store_ctl   out 2  store width select
//   extend      out 1  1 = immediate/data zero-extension variant, 0 for lb/lh
module mc_opcode_class
  import mc_pkg::*;
(
  input  logic [5:0] op,
  output logic       is_load,
  output logic       is_store,
  output logic       is_rtype,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_lui,
  output logic       is_illegal,
  output logic [1:0] load_ctl,
  output logic [1:0] store_ctl,
  output logic       extend
);

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_rtype   = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    is_lui     = 1'b0;
    is_illegal = 1'b0;
    load_ctl   = LD_BYTE;
    store_ctl  = ST_WORD;
    extend     = 1'b0;
    case (op)
      OP_LW:    begin is_load = 1'b1; load_ctl = LD_WORD; extend = 1'b1; end
      OP_LB:    begin is_load = 1'b1; end
      OP_LBU:   begin is_load = 1'b1; extend = 1'b1; end
      OP_LH:    begin is_load = 1'b1; load_ctl = LD_HALF; end
      OP_LHU:   begin is_load = 1'b1; load_ctl = LD_HALF; extend = 1'b1; end
      OP_SW:    begin is_store = 1'b1; extend = 1'b1; end
      OP_SB:    begin is_store = 1'b1; store_ctl = ST_BYTE; extend = 1'b1; end
      OP_SH:    begin is_store = 1'b1; store_ctl = ST_HALF; extend = 1'b1; end
      OP_RTYPE: is_rtype = 1'b1;
      OP_BEQ:   is_beq   = 1'b1;
      OP_J:     is_j     = 1'b1;
      OP_JAL:   is_jal   = 1'b1;
      OP_JR:    is_jr    = 1'b1;
      OP_LUI:   is_lui   = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the shared-memory MIPS datapath.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   opcode              IR[31:26], only sampled in DECODE
//   zero                ALU zero flag (branch gating happens in the datapath)
//   mem_ready           memory completes the current access this cycle
//   pc_write .. jal_control  per-state datapath selects and enables
//   instr_done          one-cycle retire pulse
//   illegal             sticky undefined-opcode flag
//   state               current state for debug
//
// state      | meaning
// FETCH      | read instruction, PC+4; waits for mem_ready
// DECODE     | latch opcode, precompute branch target
// MEM_ADDR   | base + offset address
// MEM_READ   | data read; waits for mem_ready
// MEM_WB     | load data to register file, retire
// MEM_WRITE  | data write; retires on mem_ready
// R_EXEC     | ALU op from funct
// R_WB       | ALU result to rd, retire
// BRANCH     | beq compare, conditional PC write, retire
// JUMP       | j, retire
// LUI_WB     | lui write, retire
// JR         | PC from register, retire
// JAL        | jump and link, retire
// TRAP       | undefined opcode, terminal until reset
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] store_control,
  output logic [1:0] load_control,
  output logic       extend,
  output logic       lui_control,
  output logic       jal_control,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic [5:0] class_op;
  logic       c_load, c_store, c_rtype, c_beq, c_j, c_jal, c_jr, c_lui, c_illegal;
  logic [1:0] c_load_ctl, c_store_ctl;
  logic       c_extend;

  // The branch decision is made in the datapath from zero and pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  // The IR only holds this instruction during DECODE; afterwards op_q is used.
  assign class_op = (state_q == S_DECODE) ? opcode : op_q;

  mc_opcode_class u_class (
    .op         (class_op),
    .is_load    (c_load),
    .is_store   (c_store),
    .is_rtype   (c_rtype),
    .is_beq     (c_beq),
    .is_j       (c_j),
    .is_jal     (c_jal),
    .is_jr      (c_jr),
    .is_lui     (c_lui),
    .is_illegal (c_illegal),
    .load_ctl   (c_load_ctl),
    .store_ctl  (c_store_ctl),
    .extend     (c_extend)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Outputs are forced low while rst_n is low so an in-flight access is
  // abandoned in the same cycle, ahead of the synchronous state reset.
  assign state   = rst_n ? state_q : S_FETCH;
  assign illegal = rst_n & illegal_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dest      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;
    store_control = ST_WORD;
    load_control  = LD_BYTE;
    extend        = 1'b0;
    lui_control   = 1'b0;
    jal_control   = 1'b0;
    instr_done    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_ADD;
          pc_source = PC_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM_SH;
          if (c_load || c_store) state_d = S_MEM_ADDR;
          else if (c_rtype)      state_d = S_R_EXEC;
          else if (c_beq)        state_d = S_BRANCH;
          else if (c_j)          state_d = S_JUMP;
          else if (c_jal)        state_d = S_JAL;
          else if (c_jr)         state_d = S_JR;
          else if (c_lui)        state_d = S_LUI_WB;
          else                   state_d = S_TRAP;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          extend    = c_extend;
          state_d   = c_load ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          iord         = 1'b1;
          mem_read     = 1'b1;
          load_control = c_load_ctl;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          load_control = c_load_ctl;
          instr_done   = 1'b1;
          state_d      = S_FETCH;
        end
        S_MEM_WRITE: begin
          iord          = 1'b1;
          mem_write     = 1'b1;
          store_control = c_store_ctl;
          instr_done    = mem_ready;
          if (mem_ready) state_d = S_FETCH;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dest   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_source     = PC_ALUOUT;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PC_JUMP;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JAL: begin
          pc_write    = 1'b1;
          pc_source   = PC_JUMP;
          jal_control = 1'b1;
          reg_write   = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_source  = PC_REG;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_LUI_WB: begin
          lui_control = 1'b1;
          reg_write   = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [5:0] T_R   = 6'b000000;
  localparam logic [5:0] T_J   = 6'b000010;
  localparam logic [5:0] T_JAL = 6'b000011;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_JR  = 6'b001000;
  localparam logic [5:0] T_LUI = 6'b001111;
  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SW  = 6'b101011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_write, reg_dest, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, store_control, load_control;
  logic       extend, lui_control, jal_control, instr_done, illegal;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_write, reg_dest, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source, store_control, load_control;
    logic       extend, lui_control, jal_control, instr_done, illegal;
    logic [3:0] state;
  } vec_t;

  vec_t obs;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dest(reg_dest),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .store_control(store_control),
    .load_control(load_control), .extend(extend), .lui_control(lui_control),
    .jal_control(jal_control), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  assign obs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                mem_to_reg, reg_write, reg_dest, alu_src_a, alu_src_b, alu_op,
                pc_source, store_control, load_control, extend, lui_control,
                jal_control, instr_done, illegal, state};

  function automatic logic [1:0] ld_width(input logic [5:0] op);
    if (op == T_LW) return 2'b10;
    if (op == T_LH || op == T_LHU) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] st_width(input logic [5:0] op);
    if (op == T_SB) return 2'b10;
    if (op == T_SH) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic vec_t expect_out(input int st, input logic [5:0] op, input logic rdy);
    vec_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  e.alu_src_b = 2'b11;
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.extend = !(op == T_LB || op == T_LH); end
      3:  begin e.iord = 1; e.mem_read = 1; e.load_control = ld_width(op); end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.load_control = ld_width(op); e.instr_done = 1; end
      5:  begin e.iord = 1; e.mem_write = 1; e.store_control = st_width(op); e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dest = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_write_cond = 1; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      10: begin e.lui_control = 1; e.reg_write = 1; e.instr_done = 1; end
      11: begin e.pc_write = 1; e.pc_source = 2'b11; e.instr_done = 1; end
      12: begin e.pc_write = 1; e.pc_source = 2'b10; e.jal_control = 1; e.reg_write = 1; e.instr_done = 1; end
      13: e.illegal = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH. fw/mw are memory wait cycles for the
  // fetch and data access, zval < 0 means random zero flag, rst_at >= 0
  // pulls rst_n low at that cycle of the instruction.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int zval, input int rst_at, input string name);
    int   st_q[$];
    bit   rdy_q[$];
    int   lat;
    int   done_at;
    vec_t exp;
    lat = 0;
    done_at = -1;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
    st_q.push_back(0); rdy_q.push_back(1'b1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom));
    case (op)
      T_LW, T_LB, T_LBU, T_LH, T_LHU: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(3); rdy_q.push_back(1'b0); end
        st_q.push_back(3); rdy_q.push_back(1'b1);
        st_q.push_back(4); rdy_q.push_back(1'($urandom));
        lat = 5 + fw + mw;
      end
      T_SW, T_SB, T_SH: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(5); rdy_q.push_back(1'b0); end
        st_q.push_back(5); rdy_q.push_back(1'b1);
        lat = 4 + fw + mw;
      end
      T_R: begin
        st_q.push_back(6); rdy_q.push_back(1'($urandom));
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
        lat = 4 + fw;
      end
      T_BEQ: begin st_q.push_back(8);  rdy_q.push_back(1'($urandom)); lat = 3 + fw; end
      T_J:   begin st_q.push_back(9);  rdy_q.push_back(1'($urandom)); lat = 3 + fw; end
      T_JAL: begin st_q.push_back(12); rdy_q.push_back(1'($urandom)); lat = 3 + fw; end
      T_JR:  begin st_q.push_back(11); rdy_q.push_back(1'($urandom)); lat = 3 + fw; end
      T_LUI: begin st_q.push_back(10); rdy_q.push_back(1'($urandom)); lat = 3 + fw; end
      default: begin st_q.push_back(13); rdy_q.push_back(1'($urandom)); end
    endcase
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      opcode    = (st_q[i] == 1) ? op : 6'($urandom);
      zero      = (zval < 0) ? 1'($urandom) : zval[0];
      if (i == rst_at) rst_n = 1'b0;
      #1;
      exp = (i == rst_at) ? vec_t'('0) : expect_out(st_q[i], op, rdy_q[i]);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h, expected %h", name, i, obs, exp);
      end
      if (obs.instr_done && done_at < 0) done_at = i + 1;
      if (i == rst_at) break;
    end
    if (rst_at >= 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b0;
      #1;
      exp = expect_out(0, op, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s after reset: got %h, expected %h", name, obs, exp);
      end
    end else if (lat > 0) begin
      n_checks++;
      if (done_at != lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, expected %0d", name, done_at, lat);
      end
    end
  endtask

  task automatic test_reset();
    vec_t exp;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      opcode = 6'($urandom);
      #1;
      n_checks++;
      if (obs !== vec_t'('0)) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h, expected 0", obs);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp = expect_out(0, 6'd0, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_rtype();
    run_instr(T_R, 0, 0, -1, -1, "rtype");
  endtask

  task automatic test_lh_wait();
    run_instr(T_LH, 0, 3, -1, -1, "lh_wait3");
  endtask

  task automatic test_back_to_back();
    run_instr(T_SB, 0, 0, -1, -1, "sb");
    run_instr(T_SW, 0, 0, -1, -1, "sw");
  endtask

  task automatic test_beq();
    run_instr(T_BEQ, 0, 0, 1, -1, "beq_zero1");
    run_instr(T_BEQ, 0, 0, 0, -1, "beq_zero0");
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    ops = '{T_R, T_J, T_JAL, T_BEQ, T_JR, T_LUI, T_LB, T_LH, T_LW, T_LBU,
            T_LHU, T_SB, T_SH, T_SW};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(13, 0)], $urandom_range(2, 0),
                $urandom_range(3, 0), -1, -1, "random");
    end
  endtask

  task automatic test_reset_mid_write();
    // FETCH, DECODE, MEM_ADDR, then reset in the first MEM_WRITE wait cycle.
    run_instr(T_SW, 0, 2, -1, 3, "reset_mid_write");
  endtask

  task automatic test_trap();
    vec_t exp;
    run_instr(6'b111111, 0, 0, -1, -1, "trap_entry");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      #1;
      exp = expect_out(13, 6'b111111, mem_ready);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL trap_hold cycle %0d: got %h, expected %h", i, obs, exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp = expect_out(0, 6'd0, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL trap_reset: got %h, expected %h", obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lh_wait();
    test_back_to_back();
    test_beq();
    test_random();
    test_reset_mid_write();
    test_trap();
    run_instr(T_LW, 1, 1, -1, -1, "lw_after_trap");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
